// File: rtl/display_frame_regs.sv
// Frame-synchronous register bank between the game processor and the VGA renderer.
// Shadow writes are copied to the renderer outputs only at a frame boundary; also times the title screen.
module display_frame_regs #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BALL_SIZE    = 10,
   parameter int PADDLE_H     = 40,
   parameter int TITLE_FRAMES = 180
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        vs_in,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [2:0]  wr_addr,
   input  logic [9:0]  wr_data,
   output logic [9:0]  ball_x,
   output logic [9:0]  ball_y,
   output logic [8:0]  paddle_left_y,
   output logic [8:0]  paddle_right_y,
   output logic [7:0]  score,
   output logic        title_active,
   output logic        commit_pending,
   output logic [15:0] frame_count,
   output logic        addr_err
);

   localparam logic [9:0] BX_MAX    = 10'(H_ACTIVE - BALL_SIZE);
   localparam logic [9:0] BY_MAX    = 10'(V_ACTIVE - BALL_SIZE);
   localparam logic [8:0] PAD_MAX   = 9'(V_ACTIVE - PADDLE_H);
   localparam logic [7:0] SCORE_MAX = 8'd99;
   localparam int         TW        = $clog2(TITLE_FRAMES + 1);
   localparam logic [TW-1:0] TITLE_LIM = TW'(TITLE_FRAMES);

   localparam logic [2:0] A_BALL_X   = 3'd0;
   localparam logic [2:0] A_BALL_Y   = 3'd1;
   localparam logic [2:0] A_PAD_L    = 3'd2;
   localparam logic [2:0] A_PAD_R    = 3'd3;
   localparam logic [2:0] A_SCORE    = 3'd4;
   localparam logic [2:0] A_CTRL     = 3'd5;
   localparam logic [2:0] A_RESERVED = 3'd6;
   localparam logic [2:0] A_COMMIT   = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_PENDING, S_COMMIT} state_t;

   function automatic logic [9:0] sat_u10(input logic [9:0] v, input logic [9:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic [8:0] sat_u9(input logic [8:0] v, input logic [8:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic logic [7:0] sat_u8(input logic [7:0] v, input logic [7:0] lim);
      return (v > lim) ? lim : v;
   endfunction

   state_t        state, state_nxt;
   logic          vs_p0, vs_p1;
   logic          frame_tick;
   logic          wr_acc;
   logic          title_restart;
   logic [TW-1:0] title_cnt, title_cnt_nxt;
   logic [9:0]    sh_ball_x, sh_ball_y;
   logic [8:0]    sh_pad_l, sh_pad_r;
   logic [7:0]    sh_score;

   // Stage p0/p1: vs_in registered, then delayed once more for falling-edge detect.
   // Both reset high so the first cycle out of reset never produces a tick.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         vs_p0 <= 1'b1;
         vs_p1 <= 1'b1;
      end else begin
         vs_p0 <= vs_in;
         vs_p1 <= vs_p0;
      end
   end

   assign frame_tick    = vs_p1 & ~vs_p0;
   // Only the COMMIT cycle stalls writes; this avoids a loop through wr_ready.
   assign wr_acc        = wr_valid && (state != S_COMMIT);
   assign title_restart = wr_acc && (wr_addr == A_CTRL) && wr_data[0];

   always_ff @(posedge vga_clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      wr_ready       = 1'b1;
      commit_pending = 1'b0;
      case (state)
         S_IDLE: begin
            if (wr_acc && (wr_addr == A_COMMIT)) state_nxt = S_PENDING;
         end
         S_PENDING: begin
            commit_pending = 1'b1;
            if (frame_tick) state_nxt = S_COMMIT;
         end
         S_COMMIT: begin
            commit_pending = 1'b1;
            wr_ready       = 1'b0;
            state_nxt      = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         sh_ball_x <= '0;
         sh_ball_y <= '0;
         sh_pad_l  <= '0;
         sh_pad_r  <= '0;
         sh_score  <= '0;
         addr_err  <= 1'b0;
      end else if (wr_acc) begin
         case (wr_addr)
            A_BALL_X:   sh_ball_x <= sat_u10(wr_data, BX_MAX);
            A_BALL_Y:   sh_ball_y <= sat_u10(wr_data, BY_MAX);
            A_PAD_L:    sh_pad_l  <= sat_u9(wr_data[8:0], PAD_MAX);
            A_PAD_R:    sh_pad_r  <= sat_u9(wr_data[8:0], PAD_MAX);
            A_SCORE:    sh_score  <= sat_u8(wr_data[7:0], SCORE_MAX);
            A_RESERVED: addr_err  <= 1'b1;
            default: ;
         endcase
      end
   end

   // Renderer-facing copy happens only in COMMIT, so a frame never sees a partial update.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         ball_x         <= '0;
         ball_y         <= '0;
         paddle_left_y  <= '0;
         paddle_right_y <= '0;
         score          <= '0;
      end else if (state == S_COMMIT) begin
         ball_x         <= sh_ball_x;
         ball_y         <= sh_ball_y;
         paddle_left_y  <= sh_pad_l;
         paddle_right_y <= sh_pad_r;
         score          <= sh_score;
      end
   end

   always_comb begin
      title_cnt_nxt = title_cnt;
      if (title_restart)
         title_cnt_nxt = '0;
      else if (frame_tick && (title_cnt < TITLE_LIM))
         title_cnt_nxt = title_cnt + 1'b1;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         title_cnt    <= '0;
         title_active <= 1'b1;
         frame_count  <= '0;
      end else begin
         title_cnt    <= title_cnt_nxt;
         title_active <= (title_cnt_nxt < TITLE_LIM);
         if (frame_tick) frame_count <= frame_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_display_frame_regs.sv
// Bench for display_frame_regs: directed scenarios plus randomized traffic against a frame-level model.
module tb_display_frame_regs;

   logic        vga_clk = 1'b0;
   logic        reset, vs_in, wr_valid, wr_ready;
   logic [2:0]  wr_addr;
   logic [9:0]  wr_data;
   logic [9:0]  ball_x, ball_y;
   logic [8:0]  paddle_left_y, paddle_right_y;
   logic [7:0]  score;
   logic        title_active, commit_pending, addr_err;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;

   display_frame_regs dut (
      .vga_clk(vga_clk), .reset(reset), .vs_in(vs_in),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .ball_x(ball_x), .ball_y(ball_y),
      .paddle_left_y(paddle_left_y), .paddle_right_y(paddle_right_y),
      .score(score), .title_active(title_active), .commit_pending(commit_pending),
      .frame_count(frame_count), .addr_err(addr_err)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: shadow/committed values as arrays indexed by address,
   // a pending flag, a "copy this cycle" flag, and plain integer counters.
   int m_lim [5] = '{630, 470, 440, 440, 99};
   int m_sh  [5];
   int m_out [5];
   bit m_pend, m_copy, m_aerr, m_vq, m_vprev, m_valid;
   bit m_tick, m_acc, m_op, m_oc;
   int m_title, m_fc, m_d;

   initial begin
      m_valid = 0;
      forever begin
         @(posedge vga_clk);
         if (reset) begin
            foreach (m_sh[i]) begin m_sh[i] = 0; m_out[i] = 0; end
            m_pend = 0; m_copy = 0; m_aerr = 0; m_vq = 1; m_vprev = 1;
            m_title = 0; m_fc = 0; m_valid = 1;
         end else begin
            m_tick = m_vprev && !m_vq;
            m_acc  = wr_valid && !m_copy;
            m_op   = m_pend;
            m_oc   = m_copy;
            if (m_oc) foreach (m_sh[i]) m_out[i] = m_sh[i];
            if (m_acc && wr_addr <= 3'd4) begin
               m_d = int'(wr_data);
               if (wr_addr == 3'd4)      m_d = m_d % 256;
               else if (wr_addr >= 3'd2) m_d = m_d % 512;
               m_sh[wr_addr] = (m_d > m_lim[wr_addr]) ? m_lim[wr_addr] : m_d;
            end
            if (m_acc && wr_addr == 3'd6) m_aerr = 1;
            m_copy = m_op && m_tick;
            m_pend = m_oc ? 1'b0 : (m_op ? !m_tick : (m_acc && wr_addr == 3'd7));
            if (m_acc && wr_addr == 3'd5 && wr_data[0]) m_title = 0;
            else if (m_tick && m_title < 180)           m_title++;
            if (m_tick) m_fc = (m_fc + 1) % 65536;
            m_vprev = m_vq;
            m_vq    = vs_in;
         end
      end
   end

   initial begin
      forever begin
         @(negedge vga_clk);
         if (m_valid) begin
            check_val("m_wr_ready",       wr_ready,       !m_copy);
            check_val("m_commit_pending", commit_pending, m_pend || m_copy);
            check_val("m_ball_x",         ball_x,         m_out[0]);
            check_val("m_ball_y",         ball_y,         m_out[1]);
            check_val("m_paddle_left_y",  paddle_left_y,  m_out[2]);
            check_val("m_paddle_right_y", paddle_right_y, m_out[3]);
            check_val("m_score",          score,          m_out[4]);
            check_val("m_title_active",   title_active,   m_title < 180);
            check_val("m_frame_count",    frame_count,    m_fc);
            check_val("m_addr_err",       addr_err,       m_aerr);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge vga_clk); #1; end
   endtask

   task automatic wr(input logic [2:0] a, input logic [9:0] d);
      logic r;
      bit   done = 0;
      wr_valid = 1; wr_addr = a; wr_data = d;
      for (int i = 0; i < 8 && !done; i++) begin
         @(negedge vga_clk); r = wr_ready;
         @(posedge vga_clk); #1;
         done = r;
      end
      wr_valid = 0;
      if (!done) check_val("wr_accept", 0, 1);
   endtask

   task automatic vs_pulse();
      vs_in = 0; cyc(2);
      vs_in = 1; cyc(2);
   endtask

   task automatic do_reset();
      reset = 1; cyc(2);
      reset = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic r;
      reset = 1; vs_in = 1; wr_valid = 0; wr_addr = '0; wr_data = '0;
      cyc(1);
      do_reset();
      check_val("rst_ball_x", ball_x, 0);
      check_val("rst_wr_ready", wr_ready, 1);
      check_val("rst_title", title_active, 1);
      check_val("rst_pending", commit_pending, 0);

      // Basic commit: values appear one cycle after the tick cycle.
      wr(0, 100); wr(1, 50); wr(7, 0);
      check_val("t1_pending", commit_pending, 1);
      vs_in = 0; cyc(1);
      check_val("t1_tick_ball_x", ball_x, 0);
      cyc(1);
      check_val("t1_commit_ready", wr_ready, 0);
      check_val("t1_commit_ball_x", ball_x, 0);
      cyc(1);
      check_val("t1_ball_x", ball_x, 100);
      check_val("t1_ball_y", ball_y, 50);
      check_val("t1_pending_fall", commit_pending, 0);
      vs_in = 1; cyc(2);

      // Clamping.
      wr(0, 700); wr(2, 500); wr(4, 150); wr(7, 0);
      vs_pulse();
      check_val("t2_ball_x_clamp", ball_x, 630);
      check_val("t2_pad_l_clamp", paddle_left_y, 440);
      check_val("t2_score_clamp", score, 99);

      // Write held across the COMMIT stall.
      wr(7, 0);
      vs_in = 0; cyc(1);
      check_val("t3_ready_tick", wr_ready, 1);
      cyc(1);
      check_val("t3_ready_commit", wr_ready, 0);
      wr_valid = 1; wr_addr = 3'd0; wr_data = 10'd200;
      cyc(1);
      check_val("t3_ready_after", wr_ready, 1);
      check_val("t3_ball_x_old", ball_x, 630);
      cyc(1);
      wr_valid = 0; vs_in = 1;
      check_val("t3_ball_x_hidden", ball_x, 630);
      wr(7, 0); vs_pulse();
      check_val("t3_ball_x_new", ball_x, 200);

      // Commit accepted in the same cycle as a tick from IDLE waits for the next tick.
      wr(1, 77);
      vs_in = 0; cyc(1);
      wr_valid = 1; wr_addr = 3'd7; wr_data = '0;
      cyc(1);
      wr_valid = 0; vs_in = 1;
      check_val("t4_pending", commit_pending, 1);
      cyc(3);
      check_val("t4_no_copy", ball_y, 50);
      vs_pulse();
      check_val("t4_copy", ball_y, 77);
      check_val("t4_pending_fall", commit_pending, 0);

      // Title window.
      do_reset();
      repeat (179) vs_pulse();
      check_val("t5_title_179", title_active, 1);
      vs_pulse();
      check_val("t5_title_180", title_active, 0);
      check_val("t5_frames_180", frame_count, 180);
      wr(5, 2);
      check_val("t5_ctrl_bit1", title_active, 0);
      wr(5, 1);
      check_val("t5_restart", title_active, 1);
      repeat (179) vs_pulse();
      check_val("t5_title_r179", title_active, 1);
      vs_pulse();
      check_val("t5_title_r180", title_active, 0);

      // Reserved address, then reset while pending.
      wr(6, 10'd1023);
      check_val("t6_addr_err", addr_err, 1);
      check_val("t6_ball_x", ball_x, 0);
      wr(0, 300); wr(7, 0);
      check_val("t6_addr_err_sticky", addr_err, 1);
      check_val("t6_pending", commit_pending, 1);
      do_reset();
      check_val("t6_rst_pending", commit_pending, 0);
      check_val("t6_rst_addr_err", addr_err, 0);
      vs_pulse();
      check_val("t6_no_commit", ball_x, 0);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         @(negedge vga_clk); r = wr_ready;
         @(posedge vga_clk); #1;
         reset = ($urandom_range(0, 399) == 0);
         vs_in = ($urandom_range(0, 5) != 0);
         if (!(wr_valid && !r)) begin
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
               0:       wr_data = 10'($urandom_range(0, 1023));
               1:       wr_data = 10'($urandom_range(438, 442));
               2:       wr_data = 10'($urandom_range(468, 472));
               default: wr_data = 10'($urandom_range(97, 101) + (($urandom_range(0, 1) == 1) ? 530 : 0));
            endcase
         end
      end
      wr_valid = 0; reset = 0; vs_in = 1;
      cyc(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_frame_regs.md
Name: display_frame_regs

Overview:
- Frame-synchronous register bank and sequencer that sits between the game processor and the VGA renderer.
- The processor writes ball, paddle and score values through a valid/ready port into shadow registers.
- A commit request makes the block copy all shadow values to the renderer-facing outputs at the next frame boundary, so the renderer never shows a half-updated frame.
- The block also sequences the startup title-screen window, counted in frames.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BALL_SIZE, 10, ball edge length in pixels.
- PADDLE_H, 40, paddle height in pixels.
- TITLE_FRAMES, 180, number of frames the title is shown after reset or restart.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- vs_in  in  1  vertical sync from the sync generator, active low.
- wr_valid  in  1  processor write request.
- wr_ready  out  1  block can accept a write this cycle.
- wr_addr  in  3  0=ball_x, 1=ball_y, 2=paddle_left_y, 3=paddle_right_y, 4=score, 5=ctrl, 7=commit, 6=reserved.
- wr_data  in  10  write data, LSB-aligned.
- ball_x  out  10  committed ball X.
- ball_y  out  10  committed ball Y.
- paddle_left_y  out  9  committed left paddle Y.
- paddle_right_y  out  9  committed right paddle Y.
- score  out  8  committed score.
- title_active  out  1  title window is in progress.
- commit_pending  out  1  a commit is armed and waiting for the next frame boundary.
- frame_count  out  16  frame counter.
- addr_err  out  1  sticky flag for writes to the reserved address.

Behaviour:
- **Frame tick**
  - vs_in is registered once.
  - frame_tick is a 1-cycle pulse on the registered 1->0 transition of vs_in.
  - The edge detector's previous-sample register resets to 1, so no tick occurs on the first cycle after reset.
- **Reset values**
  - All shadow registers and outputs reset to 0, except wr_ready=1 and title_active=1.
  - Title counter resets to 0.
- **Write handshake**
  - A write is accepted on a cycle where wr_valid && wr_ready.
  - wr_ready=0 only in the COMMIT cycle.
  - A write held during COMMIT is accepted on the following cycle; the master holds addr and data stable.
- **Shadow write clamping**
  - ball_x clamps to H_ACTIVE-BALL_SIZE (630).
  - ball_y clamps to V_ACTIVE-BALL_SIZE (470).
  - Paddles use wr_data[8:0], clamped to V_ACTIVE-PADDLE_H (440).
  - score takes wr_data[7:0], clamped to 99.
- **Other addresses**
  - ctrl bit0=1 restarts the title: counter cleared to 0, title_active=1 on the next cycle. Other ctrl bits are ignored.
  - addr 7 arms a commit.
  - addr 6 is accepted with no effect and sets addr_err, which is cleared only by reset.
- **State machine: IDLE, PENDING, COMMIT**
  - IDLE -> PENDING on an accepted write to addr 7.
  - PENDING -> COMMIT on frame_tick.
  - COMMIT: copy all shadows to outputs in this cycle (outputs update at its end), then go to IDLE.
  - A commit write in PENDING is redundant and stays in PENDING.
  - A commit write accepted in the same cycle as frame_tick while IDLE goes to PENDING and waits for the following tick. It is not committed on that tick.
  - A shadow write in the same cycle as the PENDING->COMMIT tick is included in the copy.
  - commit_pending=1 in PENDING and COMMIT.
- **Frame counter and title window**
  - frame_count increments on every frame_tick and wraps from 0xFFFF to 0.
  - The title counter increments on frame_tick while below TITLE_FRAMES, then saturates.
  - title_active = counter < TITLE_FRAMES, registered; it drops the cycle after the 180th tick.
  - A title restart in the same cycle as a tick wins: counter=0.
- **Reset mid-operation**
  - reset asserted in PENDING or COMMIT returns to IDLE with all outputs at their reset values.
  - An armed commit is discarded.

Test Plan:
- Reset, then write ball_x=100, ball_y=50, then commit; pulse vs_in low -> ball_x/ball_y stay 0 until one cycle after frame_tick, then read 100/50; commit_pending falls.
- Write ball_x=700, paddle_left_y=500, score=150, commit, tick -> outputs 630, 440, 99.
- Hold wr_valid with addr 0 through the COMMIT cycle -> wr_ready=0 for exactly 1 cycle; the write is accepted the next cycle and is not visible until the next commit.
- Commit accepted in the same cycle as frame_tick from IDLE -> no copy on that tick; the copy happens on the next tick.
- 180 vs_in pulses after reset -> title_active falls after the 180th; write ctrl=1 -> title_active=1 again for 180 more frames; frame_count reads 180 after the first 180 pulses.
- Write addr 6 -> addr_err=1 and stays set with no output change; assert reset while PENDING -> IDLE, all outputs 0, a subsequent tick commits nothing.
